// File: rtl/text_console_writer_pkg.sv
// Shared constants, control codes and types for the text console writer.
package text_console_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;

  localparam logic [7:0] FILL_CHAR_DEF = 8'h20;

  localparam logic [7:0] CODE_BS       = 8'h08;
  localparam logic [7:0] CODE_LF       = 8'h0A;
  localparam logic [7:0] CODE_FF       = 8'h0C;
  localparam logic [7:0] CODE_CR       = 8'h0D;
  localparam logic [7:0] CODE_PRINT_LO = 8'h20;
  localparam logic [7:0] CODE_PRINT_HI = 8'h7E;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // One-hot-ish command bundle to the cursor; at most one bit is set per cycle.
  typedef struct packed {
    logic advance;
    logic newline;
    logic cr;
    logic home;
    logic back;
  } cursor_cmd_t;

endpackage

// File: rtl/text_console_writer_if.sv
// Character stream in, text RAM write port out.
interface text_console_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] char_in;
  logic                  char_valid;
  logic                  char_ready;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic                  ram_we;

  // Upstream source / RAM side.
  modport master (
    output char_in, char_valid,
    input  char_ready, ram_wdata, ram_waddr, ram_we
  );

  // Writer side.
  modport slave (
    input  char_in, char_valid,
    output char_ready, ram_wdata, ram_waddr, ram_we
  );
endinterface

// File: rtl/text_console_writer_cursor.sv
// Cursor column/row counters plus a running row-base address, so the cell
// address is row_base + col and no multiplier is needed.
module text_cursor
  import text_console_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int COLS       = COLS_DEF,
  parameter int ROWS       = ROWS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  cursor_cmd_t           cmd,
  output logic [6:0]            col,
  output logic [4:0]            row,
  output logic [ADDR_WIDTH-1:0] addr
);
  localparam logic [6:0]            COL_LAST = 7'(COLS - 1);
  localparam logic [4:0]            ROW_LAST = 5'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(COLS);

  logic [6:0]            col_q, col_d;
  logic [4:0]            row_q, row_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [4:0]            row_nx;
  logic [ADDR_WIDTH-1:0] base_nx;

  // Next cursor position from the command; row step wraps to the top.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    base_d = base_q;
    if (row_q == ROW_LAST) begin
      row_nx  = '0;
      base_nx = '0;
    end else begin
      row_nx  = row_q + 5'd1;
      base_nx = base_q + ROW_STEP;
    end
    if (cmd.home) begin
      col_d  = '0;
      row_d  = '0;
      base_d = '0;
    end else if (cmd.advance) begin
      if (col_q == COL_LAST) begin
        col_d  = '0;
        row_d  = row_nx;
        base_d = base_nx;
      end else begin
        col_d = col_q + 7'd1;
      end
    end else if (cmd.newline) begin
      col_d  = '0;
      row_d  = row_nx;
      base_d = base_nx;
    end else if (cmd.cr) begin
      col_d = '0;
    end else if (cmd.back && (col_q != '0)) begin
      col_d = col_q - 7'd1;
    end
  end

  // Cursor registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign addr = base_q + ADDR_WIDTH'(col_q);

endmodule

// File: rtl/text_console_writer.sv
// Turns a character stream into text RAM writes with cursor control codes
// and a full-screen clear sweep.
//
//   state    | meaning
//   ST_IDLE  | accepting characters, one RAM write per printable/backspace
//   ST_CLEAR | writing FILL_CHAR to every cell, one per cycle, input stalled
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int COLS       = COLS_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter logic [DATA_WIDTH-1:0] FILL_CHAR = DATA_WIDTH'(FILL_CHAR_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  text_console_writer_if.slave  bus,
  input  logic                  clear,
  output logic                  busy,
  output logic [6:0]            cursor_col,
  output logic [4:0]            cursor_row
);
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [DATA_WIDTH-1:0] C_BS = DATA_WIDTH'(CODE_BS);
  localparam logic [DATA_WIDTH-1:0] C_LF = DATA_WIDTH'(CODE_LF);
  localparam logic [DATA_WIDTH-1:0] C_FF = DATA_WIDTH'(CODE_FF);
  localparam logic [DATA_WIDTH-1:0] C_CR = DATA_WIDTH'(CODE_CR);
  localparam logic [DATA_WIDTH-1:0] C_LO = DATA_WIDTH'(CODE_PRINT_LO);
  localparam logic [DATA_WIDTH-1:0] C_HI = DATA_WIDTH'(CODE_PRINT_HI);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  char_ready;
  logic                  accept;
  cursor_cmd_t           cmd;
  logic [ADDR_WIDTH-1:0] cur_addr;

  text_cursor #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .COLS       (COLS),
    .ROWS       (ROWS)
  ) u_cursor (
    .clk  (clk),
    .rst  (rst),
    .cmd  (cmd),
    .col  (cursor_col),
    .row  (cursor_row),
    .addr (cur_addr)
  );

  // Next state, next write-port values and cursor command.
  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    cmd        = '0;
    char_ready = (state_q == ST_IDLE) && !clear && !rst;
    accept     = bus.char_valid && char_ready;
    case (state_q)
      ST_IDLE: begin
        if (clear || (accept && (bus.char_in == C_FF))) begin
          state_d  = ST_CLEAR;
          we_d     = 1'b1;
          waddr_d  = '0;
          wdata_d  = FILL_CHAR;
          cmd.home = 1'b1;
        end else if (accept) begin
          if ((bus.char_in >= C_LO) && (bus.char_in <= C_HI)) begin
            we_d        = 1'b1;
            waddr_d     = cur_addr;
            wdata_d     = bus.char_in;
            cmd.advance = 1'b1;
          end else if (bus.char_in == C_LF) begin
            cmd.newline = 1'b1;
          end else if (bus.char_in == C_CR) begin
            cmd.cr = 1'b1;
          end else if ((bus.char_in == C_BS) && (cursor_col != '0)) begin
            we_d     = 1'b1;
            waddr_d  = cur_addr - ADDR_WIDTH'(1);
            wdata_d  = FILL_CHAR;
            cmd.back = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (waddr_q == LAST_CELL) begin
          state_d = ST_IDLE;
        end else begin
          we_d    = 1'b1;
          waddr_d = waddr_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and RAM write-port registers; these drive the RAM directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy           = (state_q == ST_CLEAR);
  assign bus.char_ready = char_ready;
  assign bus.ram_we     = we_q;
  assign bus.ram_waddr  = waddr_q;
  assign bus.ram_wdata  = wdata_q;

endmodule
